// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM link (host and slave sides).
// Contents:
//   DEFAULT_ADDR_SIZE  - default RAM address/data width
//   CMD_*              - 2-bit command encodings carried in the frame MSBs
//   host_state_e       - host FSM state encoding
//   cnt_width()        - width of the host's shared bit/gap counter
package spi_ram_pkg;

    localparam int DEFAULT_ADDR_SIZE = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_OUT = 3'd1,
        ST_GAP       = 3'd2,
        ST_SHIFT_IN  = 3'd3,
        ST_DONE      = 3'd4
    } host_state_e;

    // One counter serves the frame bits, the read turnaround and the reply bits,
    // so it must hold the largest of ADDR_SIZE+1 and READ_GAP-1 (READ_GAP <= 15).
    function automatic int cnt_width(input int addr_size, input int read_gap);
        int max_v;
        max_v = (addr_size + 1 > read_gap) ? addr_size + 1 : read_gap;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register with serial in/out.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load, din   - parallel load (takes priority over shift)
//   shift, sin  - shift left by one, sin enters at bit 0
//   q           - register contents; q[WIDTH-1] is the serial output
module spi_shift_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Shift register storage: reset, load, shift or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/spi_ram_host.sv
// SPI initiator for the SPI slave / single-port RAM pair.
// Takes one RAM command per valid/ready handshake, sends it as a
// {cmd, payload} frame MSB-first on mosi under ss_n, and for read-data
// frames waits READ_GAP cycles, then collects an ADDR_SIZE-bit reply on miso.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   req_valid/req_ready/req_cmd/req_data - command request
//   rsp_valid/rsp_data              - read-data reply (one-cycle pulse / held)
//   ss_n, mosi, miso                - SPI lines (bit clock = clk)
module spi_ram_host
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int READ_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_cmd,
    input  logic [ADDR_SIZE-1:0] req_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 ss_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int FRAME_W = ADDR_SIZE + 2;
    localparam int CNT_W   = cnt_width(ADDR_SIZE, READ_GAP);

    host_state_e            state_r;
    host_state_e            state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   rd_data_r;
    logic                   ss_n_r;
    logic                   ss_n_nxt_s;
    logic                   rsp_valid_r;
    logic [ADDR_SIZE-1:0]   rsp_data_r;
    logic                   handshake_s;
    logic                   load_s;
    logic                   shift_s;
    logic                   sin_s;
    logic                   last_sample_s;
    logic [FRAME_W-1:0]     shreg_q_s;
    logic                   unused_s;

    assign req_ready     = (state_r == ST_IDLE);
    assign handshake_s   = req_valid && (state_r == ST_IDLE);
    assign sin_s         = (state_r == ST_SHIFT_IN) ? miso : 1'b0;
    assign last_sample_s = (state_r == ST_SHIFT_IN) && (cnt_r == '0);

    // The frame is shifted out with zeros entering at the bottom, so the MSB is
    // zero once the frame has left; the ADDR_SIZE reply bits never reach the top
    // two positions.  The register MSB therefore doubles as a glitch-free mosi.
    spi_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .shift (shift_s),
        .din   ({req_cmd, req_data}),
        .sin   (sin_s),
        .q     (shreg_q_s)
    );

    assign mosi     = shreg_q_s[FRAME_W-1];
    assign unused_s = ^shreg_q_s[FRAME_W-2:ADDR_SIZE-1];

    // Next-state, counter and shifter control.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_SHIFT_OUT;
                    cnt_nxt_s   = CNT_W'(FRAME_W - 1);
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT_OUT: begin
                shift_s = 1'b1;
                if (cnt_r == '0) begin
                    if (rd_data_r) begin
                        state_nxt_s = ST_GAP;
                        cnt_nxt_s   = CNT_W'(READ_GAP - 1);
                    end else begin
                        state_nxt_s = ST_DONE;
                        cnt_nxt_s   = '0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_SHIFT_IN;
                    cnt_nxt_s   = CNT_W'(ADDR_SIZE - 1);
                end else begin
                    cnt_nxt_s = cnt_r - 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                shift_s = 1'b1;
                if (cnt_r == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        // ss_n is registered from the upcoming state so it lines up with mosi.
        if ((state_nxt_s == ST_SHIFT_OUT) || (state_nxt_s == ST_GAP) ||
            (state_nxt_s == ST_SHIFT_IN)) begin
            ss_n_nxt_s = 1'b0;
        end else begin
            ss_n_nxt_s = 1'b1;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs and the latched read-data flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r   <= 1'b0;
            ss_n_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            ss_n_r      <= ss_n_nxt_s;
            rsp_valid_r <= last_sample_s;
            if (handshake_s) begin
                rd_data_r <= (req_cmd == CMD_RD_DATA);
            end else begin
                rd_data_r <= rd_data_r;
            end
            // The final reply bit is taken straight from miso alongside the
            // seven already shifted in, so the byte is ready in DONE.
            if (last_sample_s) begin
                rsp_data_r <= {shreg_q_s[ADDR_SIZE-2:0], miso};
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign ss_n      = ss_n_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_spi_ram_host.sv
// Self-checking bench for spi_ram_host: a default build against a behavioural
// SPI slave + RAM, and a READ_GAP=3 build against a fixed 0xC3 replier.
module tb_spi_ram_host;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_valid_g3;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       req_ready, req_ready_g3;
    logic       rsp_valid, rsp_valid_g3;
    logic [7:0] rsp_data, rsp_data_g3;
    logic       ss_n, ss_n_g3;
    logic       mosi, mosi_g3;

    logic       ss_a [2];
    logic       mosi_a [2];
    logic       rv_a [2];
    logic       miso_a [2];

    int         n_c [2]        = '{0, 0};
    int         hi_cnt [2]     = '{0, 0};
    int         hi_len [2]     = '{0, 0};
    int         low_len [2]    = '{0, 0};
    int         rsp_cnt [2]    = '{0, 0};
    logic [9:0] sh_c [2];
    logic [9:0] last_frame [2];
    logic [7:0] mem [256];
    logic [7:0] ram_addr;
    logic [7:0] rd_addr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        int         low;
        int         rsp;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [13];

    spi_ram_host dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .ss_n(ss_n), .mosi(mosi), .miso(miso_a[0])
    );

    spi_ram_host #(.READ_GAP(3)) dut_g3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_g3), .req_ready(req_ready_g3),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid_g3),
        .rsp_data(rsp_data_g3), .ss_n(ss_n_g3), .mosi(mosi_g3), .miso(miso_a[1])
    );

    assign ss_a[0]   = ss_n;
    assign ss_a[1]   = ss_n_g3;
    assign mosi_a[0] = mosi;
    assign mosi_a[1] = mosi_g3;
    assign rv_a[0]   = rsp_valid;
    assign rv_a[1]   = rsp_valid_g3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reply bit the slave drives in frame cycle n (cycles 0..9 carry the frame).
    function automatic logic reply_bit(input int i, input int n);
        int         g;
        logic [7:0] b;
        g = (i == 0) ? 2 : 3;
        b = (i == 0) ? mem[rd_addr] : 8'hC3;
        if (n >= 10 + g && n <= 17 + g) return b[17 + g - n];
        return 1'b0;
    endfunction

    // Slave / RAM models and line monitors, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rv_a[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
            if (ss_a[i]) begin
                hi_cnt[i] <= hi_cnt[i] + 1;
                if (n_c[i] > 0) begin
                    low_len[i]    <= n_c[i];
                    last_frame[i] <= sh_c[i];
                end
                if (i == 0 && n_c[i] >= 10) begin
                    case (sh_c[0][9:8])
                        2'b00:   ram_addr      <= sh_c[0][7:0];
                        2'b01:   mem[ram_addr] <= sh_c[0][7:0];
                        2'b10:   rd_addr       <= sh_c[0][7:0];
                        default: ;
                    endcase
                end
                n_c[i]    <= 0;
                miso_a[i] <= 1'b0;
            end else begin
                if (n_c[i] == 0) hi_len[i] <= hi_cnt[i];
                hi_cnt[i] <= 0;
                n_c[i]    <= n_c[i] + 1;
                if (n_c[i] < 10) sh_c[i] <= {sh_c[i][8:0], mosi_a[i]};
                miso_a[i] <= reply_bit(i, n_c[i]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? req_ready : req_ready_g3;
    endfunction

    // One command on DUT w; request lines are scrambled right after the handshake.
    task automatic send(input int w, input logic [1:0] c, input logic [7:0] d, output int nrsp);
        int t;
        int rc0;
        t = 0;
        @(negedge clk);
        while (!rdy(w) && t < 100) begin @(negedge clk); t++; end
        check("ready_before_req", {31'd0, rdy(w)}, 32'd1);
        rc0      = rsp_cnt[w];
        req_cmd  = c;
        req_data = d;
        if (w == 0) req_valid = 1'b1; else req_valid_g3 = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_valid_g3 = 1'b0;
        req_cmd      = ~c;
        req_data     = 8'hFF;
        t = 0;
        @(negedge clk);
        while (!rdy(w) && t < 100) begin @(negedge clk); t++; end
        check("frame_end_timeout", {31'd0, rdy(w)}, 32'd1);
        nrsp = rsp_cnt[w] - rc0;
    endtask

    initial begin
        int         nrsp;
        int         t;
        int         rc0;
        logic [7:0] exp_hold;

        vecs[0]  = '{2'b00, 8'h3C, 10, 0, 8'h00};
        vecs[1]  = '{2'b00, 8'h10, 10, 0, 8'h00};
        vecs[2]  = '{2'b01, 8'hA5, 10, 0, 8'h00};
        vecs[3]  = '{2'b10, 8'h10, 10, 0, 8'h00};
        vecs[4]  = '{2'b11, 8'h00, 20, 1, 8'hA5};
        vecs[5]  = '{2'b01, 8'h5A, 10, 0, 8'h00};
        vecs[6]  = '{2'b11, 8'h00, 20, 1, 8'h5A};
        vecs[7]  = '{2'b00, 8'h20, 10, 0, 8'h00};
        vecs[8]  = '{2'b01, 8'h3C, 10, 0, 8'h00};
        vecs[9]  = '{2'b10, 8'h20, 10, 0, 8'h00};
        vecs[10] = '{2'b11, 8'hFF, 20, 1, 8'h3C};
        vecs[11] = '{2'b10, 8'h10, 10, 0, 8'h00};
        vecs[12] = '{2'b11, 8'h00, 20, 1, 8'h5A};

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_valid_g3 = 1'b0;
        req_cmd      = 2'b00;
        req_data     = 8'h00;
        exp_hold     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ss_n", {31'd0, ss_n}, 32'd1);
        check("reset_mosi", {31'd0, mosi}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_g3_ss_n", {31'd0, ss_n_g3}, 32'd1);
        check("reset_g3_rsp_data", {24'd0, rsp_data_g3}, 32'd0);
        rst_n = 1'b1;

        // Table of single commands against the slave + RAM model.
        for (int k = 0; k < 13; k++) begin
            send(0, vecs[k].cmd, vecs[k].data, nrsp);
            check($sformatf("frame[%0d]", k), {22'd0, last_frame[0]}, {22'd0, vecs[k].cmd, vecs[k].data});
            check($sformatf("ss_low_len[%0d]", k), low_len[0], vecs[k].low);
            check($sformatf("rsp_pulses[%0d]", k), nrsp, vecs[k].rsp);
            if (vecs[k].rsp == 1) exp_hold = vecs[k].rdata;
            check($sformatf("rsp_data[%0d]", k), {24'd0, rsp_data}, {24'd0, exp_hold});
        end

        // Back-to-back: valid held high across two commands.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b00; req_data = 8'h30;
        @(posedge clk); #1;
        req_cmd = 2'b01; req_data = 8'h99;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        check("b2b_second_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_cmd = 2'b10; req_data = 8'hFF;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        check("b2b_done", {31'd0, req_ready}, 32'd1);
        check("b2b_ss_high_gap", hi_len[0], 2);
        check("b2b_second_frame", {22'd0, last_frame[0]}, 32'h199);
        send(0, 2'b10, 8'h30, nrsp);
        send(0, 2'b11, 8'h00, nrsp);
        check("b2b_readback_pulses", nrsp, 1);
        check("b2b_readback_data", {24'd0, rsp_data}, 32'h99);

        // Reset in the 4th SHIFT_OUT bit of a read-data frame.
        rc0 = rsp_cnt[0];
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b11; req_data = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midframe_ss_low", {31'd0, ss_n}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ss_n", {31'd0, ss_n}, 32'd1);
        check("midreset_mosi", {31'd0, mosi}, 32'd0);
        check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midreset_no_rsp", rsp_cnt[0] - rc0, 0);
        check("midreset_ss_stays_high", {31'd0, ss_n}, 32'd1);

        // READ_GAP = 3 build.
        send(1, 2'b11, 8'h00, nrsp);
        check("g3_rsp_pulses", nrsp, 1);
        check("g3_rsp_data", {24'd0, rsp_data_g3}, 32'hC3);
        check("g3_ss_low_len", low_len[1], 21);
        send(1, 2'b00, 8'h81, nrsp);
        check("g3_write_low_len", low_len[1], 10);
        check("g3_write_frame", {22'd0, last_frame[1]}, 32'h081);
        check("g3_write_no_rsp", nrsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_host.md
Name: spi_ram_host

Overview:
- SPI initiator that drives the SPI slave / single-port RAM pair from the far end of the link.
- Accepts RAM commands on a valid/ready request port: write-address, write-data, read-address, read-data.
- Serialises each command as a 10-bit frame on MOSI under ss_n.
- For read-data it collects the 8-bit reply from MISO and returns it on a response port.
- Used as bench host and as on-chip controller.

Parameters:
- ADDR_SIZE, 8, RAM address/data width; frame width = ADDR_SIZE+2.
- READ_GAP, 2, turnaround cycles between the last MOSI bit and the first MISO sample of a read-data frame; legal range 1..15.

Ports:
- clk  in  1  system clock; SPI bit clock equals clk, one bit per cycle.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  command request valid.
- req_ready  out  1  high when IDLE; handshake completes when req_valid && req_ready at posedge.
- req_cmd  in  2  00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data.
- req_data  in  ADDR_SIZE  payload; ignored for cmd 11 but still transmitted.
- rsp_valid  out  1  one-cycle pulse, read-data reply available.
- rsp_data  out  ADDR_SIZE  reply byte; held until next rsp_valid.
- ss_n  out  1  slave select, active-low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (rst_n low at posedge, any state):
  - state IDLE; ss_n=1, mosi=0, rsp_valid=0, rsp_data=0.
  - shift register and counters cleared.
  - An in-flight frame is abandoned: ss_n rises on the cycle after reset is sampled, and no rsp_valid is issued.
- States: IDLE, SHIFT_OUT, GAP, SHIFT_IN, DONE.
- IDLE:
  - req_ready=1; ss_n=1; mosi=0.
  - On handshake: latch frame = {req_cmd, req_data}; go SHIFT_OUT with bit counter = ADDR_SIZE+1.
- SHIFT_OUT:
  - ss_n=0; mosi = frame[counter], MSB first; one bit per cycle; ADDR_SIZE+2 cycles total.
  - First bit appears in the cycle right after the handshake.
  - After the bit-0 cycle: cmd==11 goes to GAP; otherwise goes to DONE.
- GAP:
  - ss_n=0, mosi=0 for exactly READ_GAP cycles, then SHIFT_IN.
- SHIFT_IN:
  - ss_n=0, mosi=0 for ADDR_SIZE cycles.
  - miso sampled at the posedge ending each cycle and shifted in MSB first.
  - After the last sample go to DONE.
- DONE:
  - ss_n=1 for exactly one cycle; req_ready=0.
  - rsp_valid=1 this cycle only if the frame was cmd 11, with rsp_data = assembled byte.
  - Next state IDLE.
- ss_n low duration per frame:
  - write/addr frames: ADDR_SIZE+2 cycles (10 at default).
  - read-data frames: ADDR_SIZE+2+READ_GAP+ADDR_SIZE cycles (20 at default).
- Back-to-back commands: minimum two ss_n-high cycles between frames (DONE + IDLE handshake cycle).
- Handshake and flow control:
  - req_valid held high with no ready: no side effects.
  - req_* sampled only at the handshake; later changes are ignored.
- miso is ignored outside SHIFT_IN.
- ss_n and mosi are registered outputs, glitch-free.
- req_ready is combinational from state.

Decomposition:
- Shared package spi_ram_pkg:
  - cmd encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - host state enum.
  - default ADDR_SIZE.
- Optional sub-module spi_shift_reg (parallel-load MSB-first shifter with serial in/out), shared with the slave side.
- FSM and counters stay in the top module.

Test Plan:
- Reset mid-frame: rst_n low during the 4th SHIFT_OUT bit -> next cycle ss_n=1, mosi=0, req_ready=1; no rsp_valid.
- Write-address: cmd 00, data 0x3C -> ss_n low 10 cycles; mosi = 0,0,0,0,1,1,1,1,0,0; rsp_valid stays 0.
- Full write/read sequence against the slave+RAM model:
  - 00/0x10, 01/0xA5, 10/0x10, 11/0x00.
  - Required: rsp_valid pulses once, rsp_data=0xA5; 4th frame ss_n low exactly 20 cycles.
- Back-to-back: req_valid held high with 2 queued commands -> exactly 2 ss_n-high cycles between frames; second payload is bit-exact.
- Stimulus hold: req_data changed to 0xFF one cycle after the handshake of 01/0x5A -> transmitted payload stays 0x5A.
- READ_GAP=3 build: cmd 11, miso model drives 0xC3 starting 3 cycles after bit 0 -> rsp_data=0xC3; ss_n low 21 cycles.
